// File: rtl/vga_pixel_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_out
// Purpose  : 640x480@60 scan counters, sync/blank realignment to the object
//            mux latency, and RGB332 -> 4:4:4 expansion onto the VGA DAC pins.
// Revision : 1.0  initial release
// ============================================================================
module vga_pixel_out #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int MUX_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    input  logic [7:0]  RGBIn,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] c_h_last     = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_v_last     = 11'(V_TOTAL - 1);
    localparam logic [10:0] c_h_active   = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_active   = 11'(V_ACTIVE);
    localparam logic [10:0] c_hs_start   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_vs_start   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end     = 11'(V_ACTIVE + V_FP + V_SYNC);
    // Flag word layout {active, hs_n, vs_n}; idle value keeps syncs high.
    localparam logic [2:0]  c_flags_idle = 3'b011;

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        w_active;
    logic        w_hs_n;
    logic        w_vs_n;
    logic [2:0]  w_flags;
    logic [2:0]  w_flags_dly;
    logic [2:0]  r_pipe [MUX_LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            if (r_v_cnt == c_v_last) begin
                r_v_cnt <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + 11'd1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    assign pixelX       = r_h_cnt;
    assign pixelY       = r_v_cnt;
    assign startOfFrame = (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);

    assign w_active = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
    assign w_hs_n   = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
    assign w_vs_n   = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));
    assign w_flags  = {w_active, w_hs_n, w_vs_n};

    // Delay the timing flags so they meet the mux pixel for the same coordinate.
    for (genvar i = 0; i < MUX_LATENCY; i++) begin : g_stage
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_pipe[i] <= c_flags_idle;
            end else if (i == 0) begin
                r_pipe[i] <= w_flags;
            end else begin
                r_pipe[i] <= r_pipe[(i == 0) ? 0 : i - 1];
            end
        end
    end

    assign w_flags_dly = r_pipe[MUX_LATENCY - 1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            red    <= 4'h0;
            green  <= 4'h0;
            blue   <= 4'h0;
            hSync  <= 1'b1;
            vSync  <= 1'b1;
            blankN <= 1'b0;
        end else begin
            blankN <= w_flags_dly[2];
            hSync  <= w_flags_dly[1];
            vSync  <= w_flags_dly[0];
            if (w_flags_dly[2]) begin
                red   <= {RGBIn[7:5], RGBIn[7]};
                green <= {RGBIn[4:2], RGBIn[4]};
                blue  <= {RGBIn[1:0], RGBIn[1:0]};
            end else begin
                red   <= 4'h0;
                green <= 4'h0;
                blue  <= 4'h0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_out
// Purpose  : Bench for vga_pixel_out: full-size timing at mux latency 1 and 3,
//            plus a shrunken raster to exercise frame wrap in few cycles.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_pixel_out;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   k     = 0;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]  rgb1, rgb3, rgbs;
    logic [10:0] px1, py1, px3, py3, pxs, pys;
    logic        sof1, sof3, sofs;
    logic [3:0]  r1, g1, b1, r3, g3, b3, rs, gs, bs;
    logic        hs1, vs1, bl1, hs3, vs3, bl3, hss, vss, bls;

    initial begin
        rgb1 = 8'h00;
        rgb3 = 8'h00;
        rgbs = 8'h00;
    end

    vga_pixel_out #(.MUX_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .pixelX(px1), .pixelY(py1), .startOfFrame(sof1),
        .RGBIn(rgb1), .red(r1), .green(g1), .blue(b1), .hSync(hs1), .vSync(vs1), .blankN(bl1));

    vga_pixel_out #(.MUX_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .pixelX(px3), .pixelY(py3), .startOfFrame(sof3),
        .RGBIn(rgb3), .red(r3), .green(g3), .blue(b3), .hSync(hs3), .vSync(vs3), .blankN(bl3));

    vga_pixel_out #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
                    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .MUX_LATENCY(2)) dut_s (
        .clk(clk), .reset(reset), .pixelX(pxs), .pixelY(pys), .startOfFrame(sofs),
        .RGBIn(rgbs), .red(rs), .green(gs), .blue(bs), .hSync(hss), .vSync(vss), .blankN(bls));

    initial forever #20 clk = ~clk;

    // Clocks elapsed since the last reset release; the whole model is derived from it.
    always @(posedge clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    function automatic logic [7:0] rgb_of(int x, int y, int ha);
        if (y == 0 && x == 5) return 8'hFF;
        if (y == 0 && (x == 4 || x == 6)) return 8'h00;
        if (y == 0 && x == 7) return 8'hAE;
        if (x >= ha) return 8'hFF;
        return 8'((x * 29 + y * 53 + 17) & 255);
    endfunction

    // Pixel the object mux would present at clock kk for a given mux latency.
    function automatic logic [7:0] mux_pixel(int kk, int ml, int ha, int hf, int hs, int hb,
                                             int va, int vf, int vs, int vb);
        int ht, vt, c;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (kk < ml) return 8'h00;
        c = kk - ml;
        return rgb_of(c % ht, (c / ht) % vt, ha);
    endfunction

    // Expected pins {red, green, blue, hSync, vSync, blankN} for coordinate index c.
    function automatic logic [14:0] exp_pins(int c, int ha, int hf, int hs, int hb,
                                             int va, int vf, int vs, int vb);
        int ht, vt, x, y;
        logic act, hsn, vsn;
        logic [7:0] p;
        if (c < 0) return {12'h000, 1'b1, 1'b1, 1'b0};
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        x   = c % ht;
        y   = (c / ht) % vt;
        act = (x < ha) && (y < va);
        hsn = !(x >= ha + hf && x < ha + hf + hs);
        vsn = !(y >= va + vf && y < va + vf + vs);
        p   = rgb_of(x, y, ha);
        if (!act) return {12'h000, hsn, vsn, 1'b0};
        return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0], hsn, vsn, 1'b1};
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        #1;
        rgb1 = mux_pixel(k, 1, 640, 16, 96, 48, 480, 10, 2, 33);
        rgb3 = mux_pixel(k, 3, 640, 16, 96, 48, 480, 10, 2, 33);
        rgbs = mux_pixel(k, 2, 16, 2, 4, 2, 8, 2, 2, 3);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s k=%0d got=%0h want=%0h", nm, k, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input int ml, input int ha, input int hf,
                             input int hs, input int hb, input int va, input int vf,
                             input int vs, input int vb,
                             input logic [10:0] px, input logic [10:0] py, input logic sof,
                             input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                             input logic hsy, input logic vsy, input logic bl);
        int ht, vt;
        logic [14:0] e;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        e  = exp_pins(k - ml - 1, ha, hf, hs, hb, va, vf, vs, vb);
        chk({tag, ".pixelX"}, 32'(px), k % ht);
        chk({tag, ".pixelY"}, 32'(py), (k / ht) % vt);
        chk({tag, ".sof"},    32'(sof), 32'((k % (ht * vt)) == 0));
        chk({tag, ".red"},    32'(r),   32'(e[14:11]));
        chk({tag, ".green"},  32'(g),   32'(e[10:7]));
        chk({tag, ".blue"},   32'(b),   32'(e[6:3]));
        chk({tag, ".hSync"},  32'(hsy), 32'(e[2]));
        chk({tag, ".vSync"},  32'(vsy), 32'(e[1]));
        chk({tag, ".blankN"}, 32'(bl),  32'(e[0]));
    endtask

    always @(negedge clk) begin
        check_dut("d1", 1, 640, 16, 96, 48, 480, 10, 2, 33,
                  px1, py1, sof1, r1, g1, b1, hs1, vs1, bl1);
        check_dut("d3", 3, 640, 16, 96, 48, 480, 10, 2, 33,
                  px3, py3, sof3, r3, g3, b3, hs3, vs3, bl3);
        check_dut("ds", 2, 16, 2, 4, 2, 8, 2, 2, 3,
                  pxs, pys, sofs, rs, gs, bs, hss, vss, bls);
    end

    task automatic wait_k(input int n);
        repeat (n - k) @(negedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        wait_k(2);   chk("lit.count_px", 32'(px1), 2);
        wait_k(6);   chk("lit.pre_red", 32'(r1), 0);  chk("lit.pre_blank", 32'(bl1), 1);
        wait_k(7);   chk("lit.lat_red", 32'(r1), 15); chk("lit.lat_green", 32'(g1), 15);
                     chk("lit.lat_blue", 32'(b1), 15); chk("lit.lat_blank", 32'(bl1), 1);
        wait_k(8);   chk("lit.post_red", 32'(r1), 0);
        wait_k(9);   chk("lit.exp_red", 32'(r1), 32'b1011); chk("lit.exp_green", 32'(g1), 32'b0110);
                     chk("lit.exp_blue", 32'(b1), 32'b1010); chk("lit.l3_red", 32'(r3), 15);
        wait_k(11);  chk("lit.l3_exp_red", 32'(r3), 32'b1011); chk("lit.l3_exp_blue", 32'(b3), 32'b1010);
        wait_k(242); chk("lit.s_vs_pre", 32'(vss), 1);
        wait_k(243); chk("lit.s_vs_fall", 32'(vss), 0);
        wait_k(290); chk("lit.s_vs_last", 32'(vss), 0);
        wait_k(291); chk("lit.s_vs_rise", 32'(vss), 1);
        wait_k(359); chk("lit.s_wrap_x", 32'(pxs), 23); chk("lit.s_wrap_y", 32'(pys), 14);
        wait_k(360); chk("lit.s_x0", 32'(pxs), 0); chk("lit.s_y0", 32'(pys), 0);
                     chk("lit.s_sof", 32'(sofs), 1);
        wait_k(361); chk("lit.s_sof_end", 32'(sofs), 0);
        wait_k(657); chk("lit.hs_pre", 32'(hs1), 1);
        wait_k(658); chk("lit.hs_fall", 32'(hs1), 0);
        wait_k(659); chk("lit.l3_hs_pre", 32'(hs3), 1);
        wait_k(660); chk("lit.l3_hs_fall", 32'(hs3), 0);
        wait_k(720); chk("lit.s_sof2", 32'(sofs), 1);
        wait_k(753); chk("lit.hs_last", 32'(hs1), 0);
        wait_k(754); chk("lit.hs_rise", 32'(hs1), 1);
        wait_k(1900); chk("lit.mid_blank", 32'(bl1), 1);

        #5 reset = 1'b1;
        #1;
        chk("lit.rst_px", 32'(px1), 0);  chk("lit.rst_py", 32'(py1), 0);
        chk("lit.rst_red", 32'(r1), 0);  chk("lit.rst_green", 32'(g1), 0);
        chk("lit.rst_blue", 32'(b1), 0); chk("lit.rst_hs", 32'(hs1), 1);
        chk("lit.rst_vs", 32'(vs1), 1);  chk("lit.rst_blank", 32'(bl1), 0);
        chk("lit.rst_sof", 32'(sof1), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        wait_k(1);   chk("lit.rel_px1", 32'(px1), 1);
        wait_k(2);   chk("lit.rel_px2", 32'(px1), 2);
        wait_k(800); chk("lit.rel_line_x", 32'(px1), 0); chk("lit.rel_line_y", 32'(py1), 1);
        wait_k(1700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
